// File: rtl/debounce_edge_detect_pkg.sv
// Shared definitions for the debouncer: state encoding, default parameter
// values and the parameter legality check used at elaboration.
package debounce_edge_detect_pkg;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 10;
    localparam int DEF_CNT_WIDTH     = 4;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // True when the parameter set is legal: both depths at least 2 and the
    // counter wide enough to hold stable_cycles-1.
    function automatic bit params_ok(input int sync_stages,
                                     input int stable_cycles,
                                     input int cnt_width);
        return (sync_stages >= 2) && (stable_cycles >= 2) &&
               ((longint'(1) << cnt_width) > longint'(stable_cycles - 1));
    endfunction

endpackage

// File: rtl/debounce_edge_detect_sync_chain.sv
// Metastability synchroniser: a plain flop shift chain with asynchronous
// clear. No logic is placed between stages.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_r;

    // Shift the raw input one stage further down the chain every clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= {SYNC_STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// Debouncer with edge detection: synchronises a raw asynchronous input,
// accepts a new level only after STABLE_CYCLES identical synchronised
// samples, and emits the clean level plus one-cycle rise/fall pulses.
module debounce_edge_detect
    import debounce_edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q,
    output logic rise,
    output logic fall
);

    generate
        if (!params_ok(SYNC_STAGES, STABLE_CYCLES, CNT_WIDTH)) begin : g_param_error
            $error("debounce_edge_detect: illegal SYNC_STAGES/STABLE_CYCLES/CNT_WIDTH combination");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 sync_s;
    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_next_s;
    logic                 q_r;
    logic                 q_next_s;
    logic                 rise_r;
    logic                 rise_next_s;
    logic                 fall_r;
    logic                 fall_next_s;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk (clk),
        .rst (rst),
        .d   (d_async),
        .q   (sync_s)
    );

    // Next-state, counter and output decode; a WAIT state only completes
    // after an unbroken run of samples, any opposing sample drops back.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        q_next_s     = q_r;
        rise_next_s  = 1'b0;
        fall_next_s  = 1'b0;
        case (state_r)
            IDLE_LOW: begin
                if (sync_s) begin
                    state_next_s = WAIT_HIGH;
                    cnt_next_s   = CNT_ONE;
                end else begin
                    state_next_s = IDLE_LOW;
                end
            end
            WAIT_HIGH: begin
                if (!sync_s) begin
                    state_next_s = IDLE_LOW;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = IDLE_HIGH;
                    cnt_next_s   = CNT_ZERO;
                    q_next_s     = 1'b1;
                    rise_next_s  = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!sync_s) begin
                    state_next_s = WAIT_LOW;
                    cnt_next_s   = CNT_ONE;
                end else begin
                    state_next_s = IDLE_HIGH;
                end
            end
            WAIT_LOW: begin
                if (sync_s) begin
                    state_next_s = IDLE_HIGH;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = IDLE_LOW;
                    cnt_next_s   = CNT_ZERO;
                    q_next_s     = 1'b0;
                    fall_next_s  = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_next_s = IDLE_LOW;
                cnt_next_s   = CNT_ZERO;
                q_next_s     = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE_LOW;
            cnt_r   <= CNT_ZERO;
            q_r     <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            q_r     <= q_next_s;
            rise_r  <= rise_next_s;
            fall_r  <= fall_next_s;
        end
    end

    assign q    = q_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Self-checking bench for debounce_edge_detect: a window-based reference
// model checked every cycle, plus directed latency/glitch/bounce/reset cases.
`timescale 1ns/1ns
module tb_debounce_edge_detect;

    localparam int SYNC   = 2;
    localparam int STABLE = 10;
    localparam int CW     = 4;
    localparam int LAT    = SYNC + STABLE - 1;

    logic clk = 1'b0;
    logic rst;
    logic d_async;
    logic q;
    logic rise;
    logic fall;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: d history, window of samples seen by the
    // decision logic, and expected outputs.
    bit m_q    = 1'b0;
    bit m_rise = 1'b0;
    bit m_fall = 1'b0;
    bit d_hist[$];
    bit win[$];

    debounce_edge_detect #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d_async (d_async),
        .q       (q),
        .rise    (rise),
        .fall    (fall)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the level seen at edge e is d captured SYNC edges earlier; q
    // flips to v when the last STABLE seen samples are all v and differ from q.
    initial forever begin : model
        bit s;
        bit v;
        bit same;
        @(posedge clk or posedge rst);
        if (rst) begin
            d_hist.delete();
            win.delete();
            m_q    = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
        end else begin
            s = (d_hist.size() >= SYNC) ? d_hist[d_hist.size() - SYNC] : 1'b0;
            d_hist.push_back(d_async);
            if (d_hist.size() > 16) void'(d_hist.pop_front());
            win.push_back(s);
            if (win.size() > STABLE) void'(win.pop_front());
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (win.size() == STABLE) begin
                v    = win[0];
                same = 1'b1;
                foreach (win[i]) if (win[i] != v) same = 1'b0;
                if (same && (v != m_q)) begin
                    m_q = v;
                    if (v) m_rise = 1'b1;
                    else   m_fall = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("q", {31'd0, q}, {31'd0, m_q});
        check("rise", {31'd0, rise}, {31'd0, m_rise});
        check("fall", {31'd0, fall}, {31'd0, m_fall});
        check("rise_fall_exclusive", {31'd0, rise & fall}, 32'd0);
    end

    // Drive a pattern (bit c applies in cycle c, last bit held) starting at a
    // negedge; edges are numbered from 1 and pulses are sampled 1 ns after each.
    task automatic run_pattern(input logic [63:0] pat, input int len, input int n_edges,
                               output int first_rise, output int n_rise,
                               output int first_fall, output int n_fall);
        logic [63:0] p;
        p          = pat;
        first_rise = 0;
        n_rise     = 0;
        first_fall = 0;
        n_fall     = 0;
        for (int c = 0; c < n_edges; c++) begin
            d_async = (c < len) ? p[c] : p[len-1];
            @(posedge clk);
            #1;
            if (rise === 1'b1) begin
                n_rise++;
                if (first_rise == 0) first_rise = c + 1;
            end
            if (fall === 1'b1) begin
                n_fall++;
                if (first_fall == 0) first_fall = c + 1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int fr, nr, ff, nf;
        rst     = 1'b0;
        d_async = 1'b0;
        #1 rst  = 1'b1;
        d_async = 1'b1;

        // 1. Reset held with input high, then release: one rise after full latency.
        repeat (4) begin
            @(negedge clk);
            check("reset_q", {31'd0, q}, 32'd0);
            check("reset_rise", {31'd0, rise}, 32'd0);
            check("reset_fall", {31'd0, fall}, 32'd0);
        end
        rst = 1'b0;
        run_pattern(64'h1, 1, 20, fr, nr, ff, nf);
        check("release_rise_edge", fr, 1 + LAT);
        check("release_rise_count", nr, 1);
        check("release_fall_count", nf, 0);

        // 5. Release from q=1: one fall after full latency.
        run_pattern(64'h0, 1, 25, fr, nr, ff, nf);
        check("fall_edge", ff, 1 + LAT);
        check("fall_count", nf, 1);
        check("fall_rise_count", nr, 0);

        // 2. Clean press held 200 ns.
        run_pattern(64'h1, 1, 20, fr, nr, ff, nf);
        check("press_rise_edge", fr, 12);
        check("press_rise_count", nr, 1);
        check("press_fall_count", nf, 0);
        run_pattern(64'h0, 1, 25, fr, nr, ff, nf);
        check("press_release_fall_edge", ff, 12);

        // 3. Glitch of 4 clocks never changes q.
        run_pattern(64'h0F, 5, 30, fr, nr, ff, nf);
        check("glitch_rise_count", nr, 0);
        check("glitch_fall_count", nf, 0);
        check("glitch_q", {31'd0, q}, 32'd0);

        // 4. Bounce 1,0,1,0,1 every 20 ns then hold: last 0->1 captured at edge 9.
        run_pattern(64'h133, 9, 30, fr, nr, ff, nf);
        check("bounce_rise_edge", fr, 20);
        check("bounce_rise_count", nr, 1);
        check("bounce_fall_count", nf, 0);
        run_pattern(64'h0, 1, 25, fr, nr, ff, nf);
        check("bounce_release_fall_count", nf, 1);

        // 6. Reset mid-count: after edge 7 the counter has reached 5.
        run_pattern(64'h1, 1, 7, fr, nr, ff, nf);
        check("midcount_cnt", {28'd0, dut.cnt_r}, 32'd5);
        check("midcount_state", {30'd0, dut.state_r}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midcount_reset_q", {31'd0, q}, 32'd0);
        check("midcount_reset_cnt", {28'd0, dut.cnt_r}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_pattern(64'h1, 1, 20, fr, nr, ff, nf);
        check("midcount_rerise_edge", fr, 12);
        check("midcount_rerise_count", nr, 1);
        run_pattern(64'h0, 1, 25, fr, nr, ff, nf);

        // Randomised holds with occasional resets, checked by the model.
        for (int it = 0; it < 70; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            run_pattern(($urandom_range(0, 1) == 1) ? 64'h1 : 64'h0, 1,
                        $urandom_range(1, 28), fr, nr, ff, nf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
